// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU operation codes, immediate
// formats and the ID/EX payload layout.
package rv32_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_e;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_type_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1_data;
        logic [31:0] rs2_data;
        logic [31:0] imm;
        logic [4:0]  rd_addr;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        alu_op_e     alu_op;
        logic [2:0]  funct3;
        logic        reg_write;
        logic        mem_read;
        logic        mem_write;
        logic        branch;
        logic        jump;
        logic        alu_src;
        logic        illegal;
    } idex_t;

    // alt selects SUB for funct3=000 and SRA for funct3=101
    function automatic alu_op_e alu_from_funct3(input logic [2:0] funct3, input logic alt);
        case (funct3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv32_imm_gen.sv
// Combinational RV32I immediate generator; every format is sign-extended
// from instruction bit 31. The opcode field is not needed here.
module rv32_imm_gen
    import rv32_pkg::*;
(
    input  logic [31:7] iInstr,
    input  imm_type_e   iImmType,
    output logic [31:0] oImm
);

    always_comb begin
        oImm = {{20{iInstr[31]}}, iInstr[31:20]};
        case (iImmType)
            IMM_S:   oImm = {{20{iInstr[31]}}, iInstr[31:25], iInstr[11:7]};
            IMM_B:   oImm = {{19{iInstr[31]}}, iInstr[31], iInstr[7], iInstr[30:25],
                             iInstr[11:8], 1'b0};
            IMM_U:   oImm = {iInstr[31:12], 12'b0};
            IMM_J:   oImm = {{11{iInstr[31]}}, iInstr[31], iInstr[19:12], iInstr[20],
                             iInstr[30:21], 1'b0};
            default: oImm = {{20{iInstr[31]}}, iInstr[31:20]};
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage with ID/EX register, load-use stalling and flush bubbles.
// Define ID_WB_BYPASS_EN to forward writeback data instead of stalling on it.
module id_stage
    import rv32_pkg::*;
(
    input  logic        iClk,
    input  logic        iRst,
    input  logic        iIfValid,
    output logic        oIfReady,
    input  logic [31:0] iInstr,
    input  logic [31:0] iPc,
    output logic [4:0]  oRs1Addr,
    output logic [4:0]  oRs2Addr,
    input  logic [31:0] iRs1Data,
    input  logic [31:0] iRs2Data,
    input  logic        iWbWriteEn,
    input  logic [4:0]  iWbRdAddr,
    input  logic [31:0] iWbData,
    input  logic        iExMemRead,
    input  logic [4:0]  iExRdAddr,
    input  logic        iFlush,
    output logic        oExValid,
    input  logic        iExReady,
    output logic [31:0] oExPc,
    output logic [31:0] oExRs1Data,
    output logic [31:0] oExRs2Data,
    output logic [31:0] oExImm,
    output logic [4:0]  oExRdAddr,
    output logic [4:0]  oExRs1Addr,
    output logic [4:0]  oExRs2Addr,
    output logic [3:0]  oExAluOp,
    output logic [2:0]  oExFunct3,
    output logic        oExRegWrite,
    output logic        oExMemRead,
    output logic        oExMemWrite,
    output logic        oExBranch,
    output logic        oExJump,
    output logic        oExAluSrc,
    output logic        oExIllegal
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [4:0] rd_addr, rs1_addr, rs2_addr;

    assign opcode   = iInstr[6:0];
    assign funct3   = iInstr[14:12];
    assign rd_addr  = iInstr[11:7];
    assign rs1_addr = iInstr[19:15];
    assign rs2_addr = iInstr[24:20];
    assign oRs1Addr = rs1_addr;
    assign oRs2Addr = rs2_addr;

    imm_type_e imm_type;
    alu_op_e   alu_op;
    logic      reg_write, mem_read, mem_write, branch, jump, alu_src, illegal;
    logic      rs1_used, rs2_used;

    always_comb begin
        imm_type  = IMM_I;
        alu_op    = ALU_ADD;
        reg_write = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        branch    = 1'b0;
        jump      = 1'b0;
        alu_src   = 1'b0;
        illegal   = 1'b0;
        rs1_used  = 1'b1;
        rs2_used  = 1'b0;
        case (opcode)
            OPC_LUI:    begin imm_type = IMM_U; alu_op = ALU_PASSB; reg_write = 1'b1; alu_src = 1'b1; rs1_used = 1'b0; end
            OPC_AUIPC:  begin imm_type = IMM_U; reg_write = 1'b1; alu_src = 1'b1; rs1_used = 1'b0; end
            OPC_JAL:    begin imm_type = IMM_J; reg_write = 1'b1; jump = 1'b1; alu_src = 1'b1; rs1_used = 1'b0; end
            OPC_JALR:   begin reg_write = 1'b1; jump = 1'b1; alu_src = 1'b1; end
            OPC_BRANCH: begin imm_type = IMM_B; alu_op = ALU_SUB; branch = 1'b1; rs2_used = 1'b1; end
            OPC_LOAD:   begin reg_write = 1'b1; mem_read = 1'b1; alu_src = 1'b1; end
            OPC_STORE:  begin imm_type = IMM_S; mem_write = 1'b1; alu_src = 1'b1; rs2_used = 1'b1; end
            // bit 30 of an I-immediate only means SRA for the shift encoding
            OPC_OP_IMM: begin
                alu_op    = alu_from_funct3(funct3, iInstr[30] & (funct3 == 3'b101));
                reg_write = 1'b1;
                alu_src   = 1'b1;
            end
            OPC_OP:     begin alu_op = alu_from_funct3(funct3, iInstr[30]); reg_write = 1'b1; rs2_used = 1'b1; end
            OPC_FENCE:  ;
            default:    illegal = 1'b1;
        endcase
    end

    logic [31:0] imm;

    rv32_imm_gen u_imm_gen (
        .iInstr   (iInstr[31:7]),
        .iImmType (imm_type),
        .oImm     (imm)
    );

    logic        load_use, hazard;
    logic [31:0] rs1_val, rs2_val;

    assign load_use = iExMemRead & (iExRdAddr != 5'd0) &
                      ((rs1_used & (rs1_addr == iExRdAddr)) | (rs2_used & (rs2_addr == iExRdAddr)));

`ifdef ID_WB_BYPASS_EN
    logic wb_hit_rs1, wb_hit_rs2;
    assign wb_hit_rs1 = iWbWriteEn & (iWbRdAddr != 5'd0) & (iWbRdAddr == rs1_addr);
    assign wb_hit_rs2 = iWbWriteEn & (iWbRdAddr != 5'd0) & (iWbRdAddr == rs2_addr);
    assign rs1_val    = (rs1_addr == 5'd0) ? 32'd0 : (wb_hit_rs1 ? iWbData : iRs1Data);
    assign rs2_val    = (rs2_addr == 5'd0) ? 32'd0 : (wb_hit_rs2 ? iWbData : iRs2Data);
    assign hazard     = iIfValid & load_use;
`else
    // Without forwarding, wait one cycle for the register file to hold the write.
    logic wb_hazard, wb_data_unused;
    assign wb_hazard      = iWbWriteEn & (iWbRdAddr != 5'd0) &
                            ((rs1_used & (rs1_addr == iWbRdAddr)) | (rs2_used & (rs2_addr == iWbRdAddr)));
    assign rs1_val        = (rs1_addr == 5'd0) ? 32'd0 : iRs1Data;
    assign rs2_val        = (rs2_addr == 5'd0) ? 32'd0 : iRs2Data;
    assign hazard         = iIfValid & (load_use | wb_hazard);
    assign wb_data_unused = ^iWbData;
`endif

    idex_t payload_d, payload_q;
    logic  valid_d, valid_q, advance, load_payload, if_ready;

    assign advance = ~valid_q | iExReady;

    always_comb begin
        payload_d           = '0;
        payload_d.pc        = iPc;
        payload_d.rs1_data  = rs1_val;
        payload_d.rs2_data  = rs2_val;
        payload_d.imm       = imm;
        payload_d.rd_addr   = rd_addr;
        payload_d.rs1_addr  = rs1_addr;
        payload_d.rs2_addr  = rs2_addr;
        payload_d.alu_op    = alu_op;
        payload_d.funct3    = funct3;
        payload_d.reg_write = reg_write;
        payload_d.mem_read  = mem_read;
        payload_d.mem_write = mem_write;
        payload_d.branch    = branch;
        payload_d.jump      = jump;
        payload_d.alu_src   = alu_src;
        payload_d.illegal   = illegal;
    end

    always_comb begin
        valid_d      = valid_q;
        load_payload = 1'b0;
        if_ready     = 1'b0;
        if (iFlush) begin
            valid_d  = 1'b0;
            if_ready = 1'b1;
        end else if (!advance) begin
            valid_d  = valid_q;
        end else if (hazard) begin
            valid_d  = 1'b0;
        end else begin
            valid_d      = iIfValid;
            load_payload = iIfValid;
            if_ready     = 1'b1;
        end
    end

    assign oIfReady = if_ready & ~iRst;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q <= valid_d;
            if (load_payload) payload_q <= payload_d;
        end
    end

    assign oExValid    = valid_q;
    assign oExPc       = payload_q.pc;
    assign oExRs1Data  = payload_q.rs1_data;
    assign oExRs2Data  = payload_q.rs2_data;
    assign oExImm      = payload_q.imm;
    assign oExRdAddr   = payload_q.rd_addr;
    assign oExRs1Addr  = payload_q.rs1_addr;
    assign oExRs2Addr  = payload_q.rs2_addr;
    assign oExAluOp    = payload_q.alu_op;
    assign oExFunct3   = payload_q.funct3;
    assign oExRegWrite = payload_q.reg_write;
    assign oExMemRead  = payload_q.mem_read;
    assign oExMemWrite = payload_q.mem_write;
    assign oExBranch   = payload_q.branch;
    assign oExJump     = payload_q.jump;
    assign oExAluSrc   = payload_q.alu_src;
    assign oExIllegal  = payload_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Scoreboard bench for id_stage: directed decode/hazard/flush/bypass cases,
// then randomized traffic against a behavioural decode model.
module tb_id_stage;
    import rv32_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, if_valid, wb_en, ex_mem_read, flush, ex_ready;
    logic [31:0] instr, pc, rs1_data, rs2_data, wb_data;
    logic [4:0]  wb_rd, ex_rd;
    logic        if_ready, ex_valid;
    logic [4:0]  rs1_addr, rs2_addr, x_rd, x_rs1, x_rs2;
    logic [31:0] x_pc, x_d1, x_d2, x_imm;
    logic [3:0]  x_alu;
    logic [2:0]  x_f3;
    logic        x_rw, x_mr, x_mw, x_br, x_jp, x_src, x_ill;

    id_stage dut (
        .iClk(clk), .iRst(rst), .iIfValid(if_valid), .oIfReady(if_ready),
        .iInstr(instr), .iPc(pc), .oRs1Addr(rs1_addr), .oRs2Addr(rs2_addr),
        .iRs1Data(rs1_data), .iRs2Data(rs2_data), .iWbWriteEn(wb_en),
        .iWbRdAddr(wb_rd), .iWbData(wb_data), .iExMemRead(ex_mem_read),
        .iExRdAddr(ex_rd), .iFlush(flush), .oExValid(ex_valid), .iExReady(ex_ready),
        .oExPc(x_pc), .oExRs1Data(x_d1), .oExRs2Data(x_d2), .oExImm(x_imm),
        .oExRdAddr(x_rd), .oExRs1Addr(x_rs1), .oExRs2Addr(x_rs2), .oExAluOp(x_alu),
        .oExFunct3(x_f3), .oExRegWrite(x_rw), .oExMemRead(x_mr), .oExMemWrite(x_mw),
        .oExBranch(x_br), .oExJump(x_jp), .oExAluSrc(x_src), .oExIllegal(x_ill)
    );

    typedef struct packed {
        logic [31:0] pc, d1, d2, imm;
        logic [4:0]  rd, rs1, rs2;
        logic [3:0]  alu;
        logic [2:0]  f3;
        logic        rw, mr, mw, br, jp, src, ill;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    bit   m_valid = 1'b0;
    bit   m_next  = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
        return 32'($signed(v << (32 - bits)) >>> (32 - bits));
    endfunction

    function automatic logic [3:0] arith(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic bit uses_rs1(input logic [6:0] op);
        return !(op == 7'h37 || op == 7'h17 || op == 7'h6F);
    endfunction

    function automatic bit uses_rs2(input logic [6:0] op);
        return (op == 7'h63 || op == 7'h23 || op == 7'h33);
    endfunction

    function automatic logic [31:0] operand(input logic [4:0] r, input logic [31:0] rf);
        if (r == 5'd0) return 32'd0;
`ifdef ID_WB_BYPASS_EN
        if (wb_en && wb_rd == r) return wb_data;
`endif
        return rf;
    endfunction

    function automatic exp_t decode(input logic [31:0] ins);
        exp_t e = '0;
        logic [6:0] op = ins[6:0];
        e.pc  = pc;
        e.rd  = ins[11:7];
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.f3  = ins[14:12];
        e.d1  = operand(e.rs1, rs1_data);
        e.d2  = operand(e.rs2, rs2_data);
        e.imm = sext({20'b0, ins[31:20]}, 12);
        e.alu = ALU_ADD;
        case (op)
            7'h37: begin e.imm = {ins[31:12], 12'b0}; e.alu = ALU_PASSB; e.rw = 1; e.src = 1; end
            7'h17: begin e.imm = {ins[31:12], 12'b0}; e.rw = 1; e.src = 1; end
            7'h6F: begin
                e.imm = sext({11'b0, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}, 21);
                e.rw = 1; e.jp = 1; e.src = 1;
            end
            7'h67: begin e.rw = 1; e.jp = 1; e.src = 1; end
            7'h63: begin
                e.imm = sext({19'b0, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}, 13);
                e.alu = ALU_SUB; e.br = 1;
            end
            7'h03: begin e.rw = 1; e.mr = 1; e.src = 1; end
            7'h23: begin e.imm = sext({20'b0, ins[31:25], ins[11:7]}, 12); e.mw = 1; e.src = 1; end
            7'h13: begin e.alu = arith(ins[14:12], ins[14:12] == 3'd5 && ins[30]); e.rw = 1; e.src = 1; end
            7'h33: begin e.alu = arith(ins[14:12], ins[30]); e.rw = 1; end
            7'h0F: ;
            default: e.ill = 1;
        endcase
        return e;
    endfunction

    task automatic idle();
        rst = 0; if_valid = 0; instr = 32'h0000_0013; pc = 32'h0;
        rs1_data = 32'h0; rs2_data = 32'h0; wb_en = 0; wb_rd = 0; wb_data = 0;
        ex_mem_read = 0; ex_rd = 0; flush = 0; ex_ready = 1;
    endtask

    // Inputs are already applied; predict this cycle, check, then cross the edge.
    task automatic step();
        bit hit, haz, adv, exp_rdy;
        logic [4:0] r1, r2;
        bit u1, u2;
        #1;
        r1 = instr[19:15];
        r2 = instr[24:20];
        u1 = uses_rs1(instr[6:0]);
        u2 = uses_rs2(instr[6:0]);
        hit = ex_mem_read && ex_rd != 0 && ((u1 && r1 == ex_rd) || (u2 && r2 == ex_rd));
`ifndef ID_WB_BYPASS_EN
        hit = hit || (wb_en && wb_rd != 0 && ((u1 && r1 == wb_rd) || (u2 && r2 == wb_rd)));
`endif
        haz = if_valid && hit;
        adv = !m_valid || ex_ready;
        if (rst) begin
            exp_rdy = 0; m_next = 0; sb.delete();
        end else if (flush) begin
            exp_rdy = 1; m_next = 0;
            if (m_valid && !ex_ready && sb.size() > 0) void'(sb.pop_front());
        end else if (!adv) begin
            exp_rdy = 0; m_next = m_valid;
        end else if (haz) begin
            exp_rdy = 0; m_next = 0;
        end else begin
            exp_rdy = 1; m_next = if_valid;
            if (if_valid) sb.push_back(decode(instr));
        end
        chk("if_ready", 32'(if_ready), 32'(exp_rdy));
        chk("ex_valid", 32'(ex_valid), 32'(m_valid));
        chk("rs_addrs", {22'b0, rs1_addr, rs2_addr}, {22'b0, r1, r2});
        @(posedge clk);
        #1;
        m_valid = m_next;
    endtask

    exp_t me;
    always @(negedge clk) begin
        if (!rst && ex_valid === 1'b1 && ex_ready) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                me = sb.pop_front();
                chk("ex_pc", x_pc, me.pc);
                chk("ex_rs1_data", x_d1, me.d1);
                chk("ex_rs2_data", x_d2, me.d2);
                chk("ex_imm", x_imm, me.imm);
                chk("ex_regs", {17'b0, x_rd, x_rs1, x_rs2}, {17'b0, me.rd, me.rs1, me.rs2});
                chk("ex_alu_f3", {25'b0, x_alu, x_f3}, {25'b0, me.alu, me.f3});
                chk("ex_ctrl", {25'b0, x_rw, x_mr, x_mw, x_br, x_jp, x_src, x_ill},
                               {25'b0, me.rw, me.mr, me.mw, me.br, me.jp, me.src, me.ill});
            end
        end
    end

    logic [6:0] ops [11] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                             7'h23, 7'h13, 7'h33, 7'h0F, 7'h7F};

    initial begin
        idle();
        rst = 1;
        @(posedge clk);
        #1;
        step();
        step();
        rst = 0;
        chk("rst_zero_pl", x_pc | x_d1 | x_d2 | x_imm, 32'd0);
        chk("rst_zero_ctl", {16'b0, x_rw, x_mr, x_mw, x_br, x_jp, x_src, x_ill, ex_valid, x_alu, x_f3, 1'b0},
            32'd0);

        // addi x1,x0,5
        instr = 32'h0050_0093; if_valid = 1; pc = 32'h100; step();
        chk("addi_valid", 32'(ex_valid), 32'd1);
        chk("addi_imm", x_imm, 32'd5);
        chk("addi_rd", 32'(x_rd), 32'd1);
        chk("addi_rw_src", {30'b0, x_rw, x_src}, 32'd3);

        // beq x0,x0,-4
        instr = 32'hFE00_0EE3; pc = 32'h104; step();
        chk("beq_imm", x_imm, 32'hFFFF_FFFC);
        chk("beq_br_rw", {30'b0, x_br, x_rw}, 32'd2);

        // load-use: lw x2,0(x1) then add x3,x2,x1
        instr = 32'h0000_A103; pc = 32'h108; rs1_data = 32'h40; step();
        instr = 32'h0011_01B3; pc = 32'h10C; ex_mem_read = 1; ex_rd = 2; step();
        chk("lu_bubble", 32'(ex_valid), 32'd0);
        ex_mem_read = 0; ex_rd = 0; rs1_data = 32'h1234; rs2_data = 32'h40; step();
        chk("lu_issue", {26'b0, ex_valid, x_rs1}, {26'b0, 1'b1, 5'd2});

        // flush beats both a stalled EX and a hazard
        instr = 32'h0050_0093; pc = 32'h110; step();
        instr = 32'h0011_01B3; pc = 32'h114; ex_ready = 0; ex_mem_read = 1; ex_rd = 2; flush = 1;
        step();
        chk("flush_valid", 32'(ex_valid), 32'd0);
        flush = 0; ex_mem_read = 0; ex_rd = 0; ex_ready = 1;

        // writeback to x1 while ID reads x1: addi x5,x1,0
        instr = 32'h0000_8293; pc = 32'h118; rs1_data = 32'h0;
        wb_en = 1; wb_rd = 1; wb_data = 32'hDEAD_BEEF; step();
`ifdef ID_WB_BYPASS_EN
        chk("byp_first", {31'b0, ex_valid} ^ x_d1, 32'hDEAD_BEEE);
`else
        chk("byp_bubble", 32'(ex_valid), 32'd0);
`endif
        wb_en = 0; rs1_data = 32'hDEAD_BEEF; step();
        chk("byp_data", x_d1, 32'hDEAD_BEEF);
        chk("byp_valid", 32'(ex_valid), 32'd1);

        // illegal opcode
        instr = 32'h0000_007F; pc = 32'h11C; step();
        chk("ill_flags", {26'b0, x_ill, x_rw, x_mr, x_mw, x_br, x_jp}, 32'h20);

        // reset in the middle of a load-use stall with EX blocked
        instr = 32'h0050_0093; pc = 32'h120; step();
        instr = 32'h0011_01B3; ex_ready = 0; ex_mem_read = 1; ex_rd = 2; rst = 1; step();
        chk("rst_stall_valid", 32'(ex_valid), 32'd0);
        chk("rst_stall_pl", x_imm | x_pc, 32'd0);
        idle();

        for (int i = 0; i < 3000; i++) begin
            rst         = ($urandom_range(0, 299) == 0);
            if_valid    = ($urandom_range(0, 9) < 8);
            instr       = $urandom;
            instr[6:0]  = ops[$urandom_range(0, 10)];
            instr[11:7] = 5'($urandom_range(0, 3));
            instr[19:15] = 5'($urandom_range(0, 3));
            instr[24:20] = 5'($urandom_range(0, 3));
            pc          = $urandom;
            rs1_data    = $urandom;
            rs2_data    = $urandom;
            wb_en       = ($urandom_range(0, 3) == 0);
            wb_rd       = 5'($urandom_range(0, 3));
            wb_data     = $urandom;
            ex_mem_read = ($urandom_range(0, 9) < 3);
            ex_rd       = 5'($urandom_range(0, 3));
            flush       = ($urandom_range(0, 11) == 0);
            ex_ready    = ($urandom_range(0, 9) < 7);
            step();
        end

        idle();
        for (int i = 0; i < 3; i++) step();
        chk("sb_drained", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_stage.md
# id_stage

Instruction-decode stage of the RV32I pipeline, sitting between fetch and execute and directly in front of the register file. It accepts fetched instructions over a valid/ready handshake and decodes them into control fields and a sign-extended immediate. It drives the register file's source addresses and captures the returned operands, then presents everything to execute through an ID/EX pipeline register. It also owns load-use hazard stalling and branch-flush bubbles.

## Interface
- No parameters; widths are fixed at RV32I (XLEN 32, 5-bit register addresses).
- Clocking: one clock; reset is synchronous and active-high.
- iClk  in  1  clock.
- iRst  in  1  synchronous active-high reset.
- iIfValid  in  1  fetch holds a valid instruction.
- oIfReady  out  1  ID accepts the instruction this cycle.
- iInstr  in  32  instruction word.
- iPc  in  32  instruction address.
- oRs1Addr, oRs2Addr  out  5  register-file read addresses, combinational from iInstr[19:15] and iInstr[24:20].
- iRs1Data, iRs2Data  in  32  register-file read data, combinational.
- iWbWriteEn  in  1  writeback write enable, same as the register-file write port.
- iWbRdAddr  in  5  writeback destination.
- iWbData  in  32  writeback data.
- iExMemRead  in  1  the instruction currently in EX is a load.
- iExRdAddr  in  5  destination of the instruction in EX.
- iFlush  in  1  taken branch or jump resolved in EX.
- oExValid  out  1  ID/EX holds a valid instruction.
- iExReady  in  1  EX consumes ID/EX this cycle.
- oExPc, oExRs1Data, oExRs2Data, oExImm  out  32  operands.
- oExRdAddr, oExRs1Addr, oExRs2Addr  out  5.
- oExAluOp  out  4  ALU operation code.
- oExFunct3  out  3.
- oExRegWrite, oExMemRead, oExMemWrite, oExBranch, oExJump, oExAluSrc, oExIllegal  out  1.

## Operation
- Decode covers the RV32I opcodes LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP and FENCE.
  - FENCE decodes as a NOP with valid=1 and all write/mem controls at 0.
  - Any other opcode sets oExIllegal=1 and forces RegWrite, MemRead, MemWrite, Branch and Jump to 0.
- Immediate types:
  - I: [31:20].
  - S: {[31:25],[11:7]}.
  - B: {[31],[7],[30:25],[11:8],0}.
  - U: {[31:12],12'b0}.
  - J: {[31],[19:12],[20],[30:21],0}.
  - All are sign-extended from bit 31 of the instruction.
- Source usage: rs1 is used by all opcodes except LUI, AUIPC and JAL. rs2 is used only by BRANCH, STORE and OP.
- Hazard: hazard = iIfValid & iExMemRead & (iExRdAddr!=0) & ((rs1 used & rs1==iExRdAddr) | (rs2 used & rs2==iExRdAddr)).
- Advance condition: advance = !oExValid | iExReady.
- Priority each cycle (highest first):
  - iFlush: ID/EX valid <= 0, oIfReady=1, and the fetched word is discarded.
  - !advance: ID/EX holds, oIfReady=0.
  - hazard: ID/EX valid <= 0 (bubble), oIfReady=0.
  - Otherwise: ID/EX <= decoded instruction, valid <= iIfValid, oIfReady=1.
- Register x0 reads as 0 at the operand capture, independent of register-file content.
- When iIfValid=0, ID/EX loads a bubble (valid 0) on advance.

## Timing
- Decode and operand read are combinational. One-cycle latency from handshake acceptance to oExValid.
- Reset: every ID/EX output is 0, including oExValid=0 and oExIllegal=0.
- oIfReady is combinational from the current inputs and ID/EX state. It is 1 immediately after reset when iIfValid and iExReady allow.
- A load followed immediately by a dependent instruction costs exactly one bubble cycle.
- Reset asserted mid-stall clears ID/EX on the next clock edge. The stalled fetch is not consumed.
- ID/EX payload registers update only when valid is loaded. Bubbles may leave the payload unchanged.

## Configuration
- Macro: ID_WB_BYPASS_EN.
- Defined: if iWbWriteEn & iWbRdAddr!=0 & iWbRdAddr==rsN, the captured rsN operand is iWbData instead of iRsNData. No extra stall is inserted.
- Undefined: that same match is treated as a hazard and stalls one cycle. The register file then returns the written value.

## Structure
- Shared package rv32_pkg holds:
  - opcode localparams;
  - the ALU-op encoding (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, PASSB);
  - the immediate-type enum (I, S, B, U, J).
- Sub-module rv32_imm_gen: purely combinational, takes the instruction and the immediate type, and produces the 32-bit immediate.

## Test plan
- Reset, then addi x1,x0,5 (0x00500093):
  - next cycle oExValid=1, oExImm=5, oExRdAddr=1, oExRegWrite=1, oExAluSrc=1.
- beq x0,x0,-4 (0xFE000EE3):
  - oExImm=0xFFFFFFFC, oExBranch=1, oExRegWrite=0.
- Load-use, lw x2,0(x1) (0x0000A103) then add x3,x2,x1 (0x001101B3):
  - exactly one cycle with oExValid=0 and oIfReady=0;
  - then add issues with oExRs1Addr=2.
- iFlush asserted while iExReady=0 and a hazard is present:
  - next cycle oExValid=0;
  - oIfReady was 1 during the flush cycle.
- Bypass with ID_WB_BYPASS_EN defined: WB writes x1=0xDEADBEEF in the same cycle ID reads x1 while iRs1Data=0:
  - oExRs1Data=0xDEADBEEF.
  - With the macro undefined, the same stimulus gives a one-cycle bubble, then 0xDEADBEEF.
- Opcode 0x0000007F:
  - oExIllegal=1 and all write and memory controls are 0.
